id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the control unit and its CMUX bubble mux.
- Each cycle it latches the 24-bit ID control word plus operands, PC, immediate and register addresses, then presents them to EX/MEM/WB as decoded fields.
- Contains the load-use hazard FSM. This FSM drives the CMUX select back into ID and the PC / IF-ID write enables.
- Also handles external stall, flush and a saturating stall counter.

Parameters:
- DW, 32, datapath width (operands, PC, immediate)
- CW, 24, control word width
- SCW, 16, stall counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_id  in  CW  control word from the CMUX output
- pc_id  in  DW  PC of the ID instruction
- rs_data_id, rt_data_id  in  DW  register file read data
- imm_id  in  DW  extended immediate
- rs_id, rt_id, rd_id  in  5  register addresses
- stall_ext  in  1  downstream stall (hold everything)
- flush  in  1  branch/jump redirect (squash the ID instruction)
- ctrl_ex  out  CW  registered control word
- pc_ex, rs_data_ex, rt_data_ex, imm_ex  out  DW  registered datapath values
- rs_ex, rt_ex  out  5  registered source addresses
- dest_ex  out  5  resolved destination register (0 = no write)
- alu_op_ex  out  3  ctrl_ex[13:11]
- load_ex  out  1  ctrl_ex[0]
- cmux_sel  out  1  1 = force zero control word in ID (bubble)
- pc_we, ifid_we  out  1  PC and IF/ID write enables
- stall_cnt  out  SCW  saturating count of load-use stall cycles

Behaviour:
- Reset values: all registered outputs 0, FSM in RUN, cmux_sel=0, pc_we=ifid_we=1, stall_cnt=0.
- Control word bit map:
  - WB: [0] Load, [1] MemtoReg, [2] LoEnable, [3] RegFileEnable, [4] HiEnable
  - MEM: [5] MEM_MUX, [6] SE, [8:7] Size, [9] MemEnable, [10] RW
  - EX: [13:11] ALUOp, [15:14] S0_S2
  - ID: [16] RsAddrMux, [17] BaseAddrMux, [19:18] WriteDest, [20] CMUX, [21] JalAdder, [22] Jump
  - IF: [23] CondMux
- dest resolution happens at capture:
  - RegFileEnable=0 gives dest=0
  - WriteDest 01 → rt, 11 → rd, 10 → 31, 00 → 0
- Load-use hazard condition: load_ex=1, dest_ex≠0, and dest_ex equals rs_id or rt_id.
- FSM states:
  - RUN: no hazard and no stall_ext → capture ID inputs, pc_we=ifid_we=1, cmux_sel=0.
    - Hazard → go to LU_STALL. Combinationally in the same cycle: cmux_sel=1, pc_we=ifid_we=0.
    - The register captures a zero control word and dest=0 (the bubble). Datapath fields are don't-care but are captured as 0.
  - LU_STALL: exactly one cycle. The bubble is now in EX, so pc_we=ifid_we=1 and cmux_sel=0.
    - Capture the now-valid ID inputs and return to RUN.
    - A second hazard cannot occur in this state because load_ex=0.
  - HOLD: entered whenever stall_ext=1 from any state. All registers hold, pc_we=ifid_we=0.
    - On deassertion, return to RUN and re-evaluate the hazard.
- Priority: rst_n > flush > stall_ext > load-use > normal capture.
  - flush=1: capture zero control word with dest=0, pc_we=ifid_we=1, go to RUN. Flush overrides a pending hazard or a HOLD in the same cycle.
- stall_cnt increments on every cycle where cmux_sel=1 because of a load-use hazard, and saturates at all-ones.
- Latency: ID inputs appear at the outputs 1 cycle later. A bubble adds exactly 1 cycle.
- Reset mid-stall: asynchronous return to reset values. The FSM goes to RUN immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - control-bit index localparams (CTL_LOAD=0 … CTL_CONDMUX=23)
  - WriteDest encodings (WD_NONE, WD_RT, WD_R31, WD_RD)
  - FSM state encodings
- One sub-module: load_use_detect, purely combinational.
  - Inputs: load_ex, dest_ex, rs_id, rt_id. Output: hazard.
  - Reusable by the forwarding unit.

Test Plan:
1. Reset then ADDIU ctrl (RegFileEnable=1, WriteDest=01, rt_id=5): 1 cycle later dest_ex=5, ctrl_ex equals the input, and cmux_sel stays 0 throughout.
2. LBU to rt=8, followed by SUBU with rs_id=8:
   - Next cycle: cmux_sel=1, pc_we=ifid_we=0, stall_cnt=1.
   - Following cycle: ctrl_ex=0 and dest_ex=0.
   - Next: SUBU captured with dest_ex=rd.
3. LBU to rt=0, then a consumer with rs_id=0: no stall, stall_cnt stays 0.
4. stall_ext high for 3 cycles mid-stream: all outputs hold exactly, pc_we=0.
   - On release, capture resumes with the held ID values.
5. flush together with a load-use hazard:
   - ctrl_ex=0, pc_we=1, FSM in RUN, stall_cnt unchanged.
6. Assert rst_n=0 asynchronously during LU_STALL:
   - Outputs zero immediately without waiting for a clock edge.
   - After 300 forced hazards with SCW=8, stall_cnt=255.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: control-word bit indices, WriteDest encodings, ID/EX FSM states and dest resolution.
package pipe_pkg;
    localparam int CTL_LOAD        = 0;
    localparam int CTL_MEMTOREG    = 1;
    localparam int CTL_LOENABLE    = 2;
    localparam int CTL_REGFILE_EN  = 3;
    localparam int CTL_HIENABLE    = 4;
    localparam int CTL_MEM_MUX     = 5;
    localparam int CTL_SE          = 6;
    localparam int CTL_SIZE_LO     = 7;
    localparam int CTL_SIZE_HI     = 8;
    localparam int CTL_MEM_EN      = 9;
    localparam int CTL_RW          = 10;
    localparam int CTL_ALUOP_LO    = 11;
    localparam int CTL_ALUOP_HI    = 13;
    localparam int CTL_S0S2_LO     = 14;
    localparam int CTL_S0S2_HI     = 15;
    localparam int CTL_RSADDRMUX   = 16;
    localparam int CTL_BASEADDRMUX = 17;
    localparam int CTL_WDEST_LO    = 18;
    localparam int CTL_WDEST_HI    = 19;
    localparam int CTL_CMUX        = 20;
    localparam int CTL_JALADDER    = 21;
    localparam int CTL_JUMP        = 22;
    localparam int CTL_CONDMUX     = 23;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WD_NONE = 2'b00,
        WD_RT   = 2'b01,
        WD_R31  = 2'b10,
        WD_RD   = 2'b11
    } wdest_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    // A disabled register-file write always resolves to r0 so downstream
    // hazard/forwarding logic can treat dest==0 as "no write".
    function automatic logic [4:0] resolve_dest(input logic rf_en, input logic [1:0] wd,
                                                input logic [4:0] rt, input logic [4:0] rd);
        return !rf_en          ? REG_ZERO :
               wd == WD_RT     ? rt       :
               wd == WD_RD     ? rd       :
               wd == WD_R31    ? REG_RA   : REG_ZERO;
    endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard check between EX load and ID sources.
//   load_ex  - instruction in EX is a load
//   dest_ex  - destination register of the EX instruction (0 = no write)
//   rs_id    - ID source register rs
//   rt_id    - ID source register rt
//   hazard   - ID instruction needs the loaded value before it is available
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       load_ex,
    input  logic [4:0] dest_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    output logic       hazard
);
    assign hazard = load_ex && (dest_ex != REG_ZERO) && (dest_ex == rs_id || dest_ex == rt_id);
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble FSM, external stall, flush and stall counter.
//   clk, rst_n                      - clock, async active-low reset
//   ctrl_id, pc_id, rs_data_id,
//   rt_data_id, imm_id,
//   rs_id, rt_id, rd_id             - ID stage inputs
//   stall_ext                       - hold all state (downstream stall)
//   flush                           - squash the ID instruction
//   ctrl_ex, pc_ex, rs_data_ex,
//   rt_data_ex, imm_ex, rs_ex, rt_ex - registered values for EX
//   dest_ex                         - resolved destination (0 = no write)
//   alu_op_ex, load_ex              - decoded fields of ctrl_ex
//   cmux_sel                        - force zero control word in ID
//   pc_we, ifid_we                  - PC / IF-ID write enables
//   stall_cnt                       - saturating load-use stall cycle count
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int DW  = 32,
    parameter int CW  = 24,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  ctrl_id,
    input  logic [DW-1:0]  pc_id,
    input  logic [DW-1:0]  rs_data_id,
    input  logic [DW-1:0]  rt_data_id,
    input  logic [DW-1:0]  imm_id,
    input  logic [4:0]     rs_id,
    input  logic [4:0]     rt_id,
    input  logic [4:0]     rd_id,
    input  logic           stall_ext,
    input  logic           flush,
    output logic [CW-1:0]  ctrl_ex,
    output logic [DW-1:0]  pc_ex,
    output logic [DW-1:0]  rs_data_ex,
    output logic [DW-1:0]  rt_data_ex,
    output logic [DW-1:0]  imm_ex,
    output logic [4:0]     rs_ex,
    output logic [4:0]     rt_ex,
    output logic [4:0]     dest_ex,
    output logic [2:0]     alu_op_ex,
    output logic           load_ex,
    output logic           cmux_sel,
    output logic           pc_we,
    output logic           ifid_we,
    output logic [SCW-1:0] stall_cnt
);
    state_e     state;
    state_e     state_nx;
    logic       hazard;
    logic       bubble;
    logic       hold;
    logic       squash;
    logic [4:0] dest_nx;

    assign alu_op_ex = ctrl_ex[CTL_ALUOP_HI:CTL_ALUOP_LO];
    assign load_ex   = ctrl_ex[CTL_LOAD];

    load_use_detect u_lud (
        .load_ex (load_ex),
        .dest_ex (dest_ex),
        .rs_id   (rs_id),
        .rt_id   (rt_id),
        .hazard  (hazard)
    );

    // Priority flush > stall_ext > load-use > capture. The LU_STALL guard is
    // belt-and-braces: the bubble in EX already keeps load_ex low there.
    always_comb begin
        hold     = !flush && stall_ext;
        bubble   = !flush && !stall_ext && hazard && state != ST_LU_STALL;
        squash   = flush || bubble;
        cmux_sel = bubble;
        pc_we    = !(hold || bubble);
        ifid_we  = !(hold || bubble);
        state_nx = flush ? ST_RUN : stall_ext ? ST_HOLD : bubble ? ST_LU_STALL : ST_RUN;
        dest_nx  = squash ? REG_ZERO :
                   resolve_dest(ctrl_id[CTL_REGFILE_EN], ctrl_id[CTL_WDEST_HI:CTL_WDEST_LO], rt_id, rd_id);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            ctrl_ex    <= '0;
            pc_ex      <= '0;
            rs_data_ex <= '0;
            rt_data_ex <= '0;
            imm_ex     <= '0;
            rs_ex      <= '0;
            rt_ex      <= '0;
            dest_ex    <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (!hold) begin
                ctrl_ex    <= squash ? '0 : ctrl_id;
                pc_ex      <= squash ? '0 : pc_id;
                rs_data_ex <= squash ? '0 : rs_data_id;
                rt_data_ex <= squash ? '0 : rt_data_id;
                imm_ex     <= squash ? '0 : imm_id;
                rs_ex      <= squash ? '0 : rs_id;
                rt_ex      <= squash ? '0 : rt_id;
                dest_ex    <= dest_nx;
            end
            if (bubble && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed self-checking bench for id_ex_stage_reg.
module tb_id_ex_stage_reg;
    import pipe_pkg::*;

    localparam logic [23:0] C_ADDIU = 24'h041008;
    localparam logic [23:0] C_LBU   = 24'h04120B;
    localparam logic [23:0] C_SUBU  = 24'h0C1808;
    localparam logic [23:0] C_JAL   = 24'h080008;
    localparam logic [23:0] C_NORF  = 24'h0C0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] ctrl_id = '0;
    logic [31:0] pc_id = '0, rs_data_id = '0, rt_data_id = '0, imm_id = '0;
    logic [4:0]  rs_id = '0, rt_id = '0, rd_id = '0;
    logic        stall_ext = 1'b0, flush = 1'b0;
    logic [23:0] ctrl_ex;
    logic [31:0] pc_ex, rs_data_ex, rt_data_ex, imm_ex;
    logic [4:0]  rs_ex, rt_ex, dest_ex;
    logic [2:0]  alu_op_ex;
    logic        load_ex, cmux_sel, pc_we, ifid_we;
    logic [7:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage_reg #(.DW(32), .CW(24), .SCW(8)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_id(ctrl_id), .pc_id(pc_id),
        .rs_data_id(rs_data_id), .rt_data_id(rt_data_id), .imm_id(imm_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .stall_ext(stall_ext), .flush(flush),
        .ctrl_ex(ctrl_ex), .pc_ex(pc_ex), .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex),
        .imm_ex(imm_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .dest_ex(dest_ex),
        .alu_op_ex(alu_op_ex), .load_ex(load_ex), .cmux_sel(cmux_sel),
        .pc_we(pc_we), .ifid_we(ifid_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [23:0] c, input logic [31:0] pc,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ctrl_id    = c;
        pc_id      = pc;
        rs_data_id = pc ^ 32'hAAAA0000;
        rt_data_id = pc ^ 32'h5555_0000;
        imm_id     = pc + 32'h10;
        rs_id      = rs;
        rt_id      = rt;
        rd_id      = rd;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ctrl_ex !== 24'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", ctrl_ex); end
        checks++; if (pc_ex !== 32'h0 || dest_ex !== 5'd0) begin errors++; $display("FAIL reset_data pc %h dest %0d exp 0", pc_ex, dest_ex); end
        checks++; if (pc_we !== 1'b1 || ifid_we !== 1'b1 || cmux_sel !== 1'b0) begin errors++; $display("FAIL reset_ctl pc_we %b ifid_we %b cmux %b exp 1 1 0", pc_we, ifid_we, cmux_sel); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        #4 rst_n = 1'b1;
        step();
    endtask

    task automatic test_addiu();
        set_id(C_ADDIU, 32'h100, 5'd3, 5'd5, 5'd9);
        #1;
        checks++; if (cmux_sel !== 1'b0) begin errors++; $display("FAIL addiu_cmux_pre got %b exp 0", cmux_sel); end
        step();
        checks++; if (ctrl_ex !== C_ADDIU) begin errors++; $display("FAIL addiu_ctrl got %h exp %h", ctrl_ex, C_ADDIU); end
        checks++; if (dest_ex !== 5'd5) begin errors++; $display("FAIL addiu_dest got %0d exp 5", dest_ex); end
        checks++; if (pc_ex !== 32'h100 || rs_data_ex !== 32'hAAAA0100 || rt_data_ex !== 32'h55550100 || imm_ex !== 32'h110) begin
            errors++; $display("FAIL addiu_data pc %h rs %h rt %h imm %h", pc_ex, rs_data_ex, rt_data_ex, imm_ex); end
        checks++; if (rs_ex !== 5'd3 || rt_ex !== 5'd5) begin errors++; $display("FAIL addiu_regs rs %0d rt %0d exp 3 5", rs_ex, rt_ex); end
        checks++; if (alu_op_ex !== 3'b010 || load_ex !== 1'b0) begin errors++; $display("FAIL addiu_fields alu %b load %b exp 010 0", alu_op_ex, load_ex); end
        checks++; if (cmux_sel !== 1'b0 || pc_we !== 1'b1) begin errors++; $display("FAIL addiu_cmux got %b pc_we %b exp 0 1", cmux_sel, pc_we); end
    endtask

    task automatic test_dest();
        set_id(C_JAL, 32'h104, 5'd1, 5'd2, 5'd3);
        step();
        checks++; if (dest_ex !== 5'd31) begin errors++; $display("FAIL dest_r31 got %0d exp 31", dest_ex); end
        set_id(C_NORF, 32'h108, 5'd1, 5'd2, 5'd3);
        step();
        checks++; if (dest_ex !== 5'd0) begin errors++; $display("FAIL dest_norf got %0d exp 0", dest_ex); end
    endtask

    task automatic test_load_use();
        set_id(C_LBU, 32'h10C, 5'd1, 5'd8, 5'd0);
        step();
        checks++; if (load_ex !== 1'b1 || dest_ex !== 5'd8) begin errors++; $display("FAIL lu_load load %b dest %0d exp 1 8", load_ex, dest_ex); end
        set_id(C_SUBU, 32'h110, 5'd8, 5'd2, 5'd12);
        #1;
        checks++; if (cmux_sel !== 1'b1 || pc_we !== 1'b0 || ifid_we !== 1'b0) begin
            errors++; $display("FAIL lu_stall cmux %b pc_we %b ifid_we %b exp 1 0 0", cmux_sel, pc_we, ifid_we); end
        step();
        checks++; if (ctrl_ex !== 24'h0 || dest_ex !== 5'd0) begin errors++; $display("FAIL lu_bubble ctrl %h dest %0d exp 0 0", ctrl_ex, dest_ex); end
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
        checks++; if (cmux_sel !== 1'b0 || pc_we !== 1'b1) begin errors++; $display("FAIL lu_release cmux %b pc_we %b exp 0 1", cmux_sel, pc_we); end
        step();
        checks++; if (ctrl_ex !== C_SUBU || dest_ex !== 5'd12 || pc_ex !== 32'h110) begin
            errors++; $display("FAIL lu_subu ctrl %h dest %0d pc %h exp %h 12 110", ctrl_ex, dest_ex, pc_ex, C_SUBU); end
    endtask

    task automatic test_load_zero();
        set_id(C_LBU, 32'h114, 5'd1, 5'd0, 5'd0);
        step();
        checks++; if (load_ex !== 1'b1 || dest_ex !== 5'd0) begin errors++; $display("FAIL lz_load load %b dest %0d exp 1 0", load_ex, dest_ex); end
        set_id(C_SUBU, 32'h118, 5'd0, 5'd0, 5'd14);
        #1;
        checks++; if (cmux_sel !== 1'b0 || pc_we !== 1'b1) begin errors++; $display("FAIL lz_nostall cmux %b pc_we %b exp 0 1", cmux_sel, pc_we); end
        step();
        checks++; if (ctrl_ex !== C_SUBU || dest_ex !== 5'd14 || stall_cnt !== 8'd1) begin
            errors++; $display("FAIL lz_capture ctrl %h dest %0d cnt %0d exp %h 14 1", ctrl_ex, dest_ex, stall_cnt, C_SUBU); end
    endtask

    task automatic test_stall_ext();
        set_id(C_ADDIU, 32'h200, 5'd4, 5'd7, 5'd0);
        step();
        set_id(C_SUBU, 32'h204, 5'd2, 5'd3, 5'd13);
        stall_ext = 1'b1;
        #1;
        checks++; if (pc_we !== 1'b0 || ifid_we !== 1'b0) begin errors++; $display("FAIL hold_we pc_we %b ifid_we %b exp 0 0", pc_we, ifid_we); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ctrl_ex !== C_ADDIU || dest_ex !== 5'd7 || pc_ex !== 32'h200 || rs_ex !== 5'd4 || imm_ex !== 32'h210) begin
                errors++; $display("FAIL hold_cycle%0d ctrl %h dest %0d pc %h exp %h 7 200", i, ctrl_ex, dest_ex, pc_ex, C_ADDIU); end
            checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL hold_pcwe%0d got %b exp 0", i, pc_we); end
        end
        stall_ext = 1'b0;
        #1;
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL hold_release_we got %b exp 1", pc_we); end
        step();
        checks++; if (ctrl_ex !== C_SUBU || dest_ex !== 5'd13 || pc_ex !== 32'h204) begin
            errors++; $display("FAIL hold_resume ctrl %h dest %0d pc %h exp %h 13 204", ctrl_ex, dest_ex, pc_ex, C_SUBU); end
    endtask

    task automatic test_flush();
        set_id(C_LBU, 32'h300, 5'd1, 5'd8, 5'd0);
        step();
        set_id(C_SUBU, 32'h304, 5'd8, 5'd2, 5'd12);
        flush = 1'b1;
        #1;
        checks++; if (cmux_sel !== 1'b0 || pc_we !== 1'b1 || ifid_we !== 1'b1) begin
            errors++; $display("FAIL flush_we cmux %b pc_we %b ifid_we %b exp 0 1 1", cmux_sel, pc_we, ifid_we); end
        step();
        flush = 1'b0;
        checks++; if (ctrl_ex !== 24'h0 || dest_ex !== 5'd0) begin errors++; $display("FAIL flush_bubble ctrl %h dest %0d exp 0 0", ctrl_ex, dest_ex); end
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", stall_cnt); end
        checks++; if (dut.state !== ST_RUN) begin errors++; $display("FAIL flush_state got %0d exp %0d", dut.state, ST_RUN); end
        set_id(C_ADDIU, 32'h308, 5'd1, 5'd6, 5'd0);
        stall_ext = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL flush_hold_we got %b exp 1", pc_we); end
        step();
        stall_ext = 1'b0;
        flush = 1'b0;
        checks++; if (ctrl_ex !== 24'h0 || dut.state !== ST_RUN) begin errors++; $display("FAIL flush_hold ctrl %h state %0d exp 0 0", ctrl_ex, dut.state); end
    endtask

    task automatic test_async_reset();
        set_id(C_LBU, 32'h400, 5'd8, 5'd8, 5'd0);
        step();
        step();
        checks++; if (dut.state !== ST_LU_STALL) begin errors++; $display("FAIL ar_in_stall state %0d exp %0d", dut.state, ST_LU_STALL); end
        checks++; if (stall_cnt !== 8'd2) begin errors++; $display("FAIL ar_precnt got %0d exp 2", stall_cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (stall_cnt !== 8'd0 || ctrl_ex !== 24'h0 || dest_ex !== 5'd0 || pc_ex !== 32'h0) begin
            errors++; $display("FAIL ar_zero cnt %0d ctrl %h dest %0d pc %h exp 0", stall_cnt, ctrl_ex, dest_ex, pc_ex); end
        checks++; if (dut.state !== ST_RUN || pc_we !== 1'b1 || cmux_sel !== 1'b0) begin
            errors++; $display("FAIL ar_state state %0d pc_we %b cmux %b exp 0 1 0", dut.state, pc_we, cmux_sel); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 508; i++) step();
        checks++; if (stall_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", stall_cnt); end
        for (int i = 0; i < 2; i++) step();
        checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", stall_cnt); end
        for (int i = 0; i < 90; i++) step();
        checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_dest();
        test_load_use();
        test_load_zero();
        test_stall_ext();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
